// File: rtl/linebuffer_ctrl.sv
// Line buffer ring sequencer for the axis scaler.
// Write-side slot/column steering and shared read-column sweep.
module linebuffer_ctrl #(
  parameter int C_ADDRESS_WIDTH = 11,
  parameter int C_LINE_NUM      = 4,
  parameter int C_IDX_WIDTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic                       wr_en,
  output logic [C_IDX_WIDTH-1:0]     wr_sel,
  output logic [C_ADDRESS_WIDTH-1:0] wr_addr,
  output logic                       wr_ovf,
  output logic [C_IDX_WIDTH:0]       lines_avail,
  input  logic                       rd_start,
  input  logic [C_ADDRESS_WIDTH:0]   rd_width,
  output logic                       rd_busy,
  output logic [C_ADDRESS_WIDTH-1:0] rd_addr,
  output logic [C_IDX_WIDTH-1:0]     rd_base,
  output logic                       rd_dvalid,
  output logic                       rd_done,
  input  logic                       line_release
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } rd_state_t;

  localparam logic [C_ADDRESS_WIDTH-1:0] LP_COL_MAX = '1;
  localparam logic [C_IDX_WIDTH:0] LP_FULL =
    (C_IDX_WIDTH+1)'(C_LINE_NUM);
  localparam logic [C_IDX_WIDTH:0] LP_CNT_ONE =
    (C_IDX_WIDTH+1)'(1);
  localparam logic [C_IDX_WIDTH-1:0] LP_IDX_ONE =
    (C_IDX_WIDTH)'(1);
  localparam logic [C_ADDRESS_WIDTH:0] LP_W_ONE =
    (C_ADDRESS_WIDTH+1)'(1);
  localparam logic [C_ADDRESS_WIDTH-1:0] LP_A_ONE =
    (C_ADDRESS_WIDTH)'(1);

  logic                       r_rst_q;
  logic [C_IDX_WIDTH:0]       r_count;
  logic [C_IDX_WIDTH-1:0]     r_wr_idx;
  logic [C_ADDRESS_WIDTH-1:0] r_wcol;
  logic                       r_ovf_seen;
  logic [C_IDX_WIDTH-1:0]     r_rd_base;
  rd_state_t                  r_state;
  logic [C_ADDRESS_WIDTH-1:0] r_rd_addr;
  logic [C_ADDRESS_WIDTH:0]   r_width;
  logic                       r_dvalid;

  logic                       w_tready;
  logic                       w_acc;
  logic                       w_sof;
  logic                       w_commit;
  logic                       w_rel;
  logic                       w_busy;
  logic                       w_last;
  logic                       w_rd_en;
  logic                       w_rd_done;
  rd_state_t                  w_state_nxt;
  logic [C_ADDRESS_WIDTH-1:0] w_rd_addr_nxt;
  logic [C_ADDRESS_WIDTH:0]   w_width_nxt;

  assign w_tready = !r_rst_q && (r_count != LP_FULL);
  assign w_acc    = s_axis_tvalid && w_tready;
  assign w_sof    = w_acc && s_axis_tuser;
  assign w_commit = w_acc && s_axis_tlast;
  assign w_busy   = (r_state != S_IDLE);
  assign w_rel    = line_release && (r_count != '0)
                    && !w_busy && !w_sof;
  assign w_last   = ({1'b0, r_rd_addr} == (r_width - LP_W_ONE));

  assign s_axis_tready = w_tready;
  assign wr_en         = w_acc;
  assign wr_sel        = w_sof ? '0 : r_wr_idx;
  assign wr_addr       = w_sof ? '0 : r_wcol;
  // Flag only the first beat that lands on the clamped last column
  assign wr_ovf        = w_acc && !w_sof && !s_axis_tlast
                         && (r_wcol == LP_COL_MAX) && !r_ovf_seen;
  assign lines_avail   = r_count;
  assign rd_busy       = w_busy;
  assign rd_addr       = r_rd_addr;
  assign rd_base       = r_rd_base;
  assign rd_dvalid     = r_dvalid;
  assign rd_done       = w_rd_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_q    <= 1'b1;
      r_count    <= '0;
      r_wr_idx   <= '0;
      r_wcol     <= '0;
      r_ovf_seen <= 1'b0;
      r_rd_base  <= '0;
    end else begin
      r_rst_q <= 1'b0;
      if (w_sof) begin
        r_count    <= s_axis_tlast ? LP_CNT_ONE : '0;
        r_wr_idx   <= s_axis_tlast ? LP_IDX_ONE : '0;
        r_wcol     <= s_axis_tlast ? '0 : LP_A_ONE;
        r_ovf_seen <= 1'b0;
        r_rd_base  <= '0;
      end else begin
        r_count <= r_count
                   + (C_IDX_WIDTH+1)'(w_commit)
                   - (C_IDX_WIDTH+1)'(w_rel);
        if (w_rel) begin
          r_rd_base <= r_rd_base + LP_IDX_ONE;
        end
        if (w_commit) begin
          r_wcol     <= '0;
          r_wr_idx   <= r_wr_idx + LP_IDX_ONE;
          r_ovf_seen <= 1'b0;
        end else if (w_acc) begin
          if (r_wcol != LP_COL_MAX) begin
            r_wcol <= r_wcol + LP_A_ONE;
          end else begin
            r_ovf_seen <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_width   <= '0;
      r_dvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_width   <= w_width_nxt;
      r_dvalid  <= w_rd_en && !w_sof;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_width_nxt   = r_width;
    w_rd_en       = 1'b0;
    w_rd_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rd_start && (r_count != '0) && (rd_width != '0)) begin
          w_state_nxt   = S_RUN;
          w_rd_addr_nxt = '0;
          w_width_nxt   = rd_width;
        end
      end
      S_RUN: begin
        w_rd_en = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_addr_nxt = r_rd_addr + LP_A_ONE;
        end
      end
      S_DRAIN: begin
        w_rd_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // A new frame abandons any sweep in flight
    if (w_sof) begin
      w_state_nxt   = S_IDLE;
      w_rd_addr_nxt = r_rd_addr;
      w_width_nxt   = r_width;
      w_rd_done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed vector bench for linebuffer_ctrl.
// Inputs change on negedge, outputs compared 1 time unit later.
module tb_linebuffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tuser, tlast, tready;
  logic        wr_en, wr_ovf;
  logic [1:0]  wr_sel;
  logic [10:0] wr_addr;
  logic [2:0]  lines_avail;
  logic        rd_start;
  logic [11:0] rd_width;
  logic        rd_busy;
  logic [10:0] rd_addr;
  logic [1:0]  rd_base;
  logic        rd_dvalid, rd_done, line_release;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  linebuffer_ctrl #(
    .C_ADDRESS_WIDTH(11),
    .C_LINE_NUM(4),
    .C_IDX_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tvalid(tvalid),
    .s_axis_tuser(tuser),
    .s_axis_tlast(tlast),
    .s_axis_tready(tready),
    .wr_en(wr_en),
    .wr_sel(wr_sel),
    .wr_addr(wr_addr),
    .wr_ovf(wr_ovf),
    .lines_avail(lines_avail),
    .rd_start(rd_start),
    .rd_width(rd_width),
    .rd_busy(rd_busy),
    .rd_addr(rd_addr),
    .rd_base(rd_base),
    .rd_dvalid(rd_dvalid),
    .rd_done(rd_done),
    .line_release(line_release)
  );

  typedef struct {
    logic        rst, vld, usr, lst, st;
    logic [11:0] wid;
    logic        rel;
    logic        rdy, wen;
    logic [1:0]  sel;
    logic [10:0] addr;
    logic [2:0]  avail;
    logic        busy;
    logic [10:0] raddr;
    logic [1:0]  base;
    logic        dv, done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input int rs, vl, us, ls, st, wd, rl,
    input int rdy, wen, sel, ad, av, bs, ra, ba, dv, dn);
    vec_t r;
    r.rst = 1'(rs); r.vld = 1'(vl); r.usr = 1'(us);
    r.lst = 1'(ls); r.st = 1'(st); r.wid = 12'(wd);
    r.rel = 1'(rl); r.rdy = 1'(rdy); r.wen = 1'(wen);
    r.sel = 2'(sel); r.addr = 11'(ad); r.avail = 3'(av);
    r.busy = 1'(bs); r.raddr = 11'(ra); r.base = 2'(ba);
    r.dv = 1'(dv); r.done = 1'(dn);
    return r;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s row %0d got %0h exp %0h",
               nm, row, got, exp);
    end
  endtask

  task automatic drive(input logic rs, vl, us, ls, st,
                       input logic [11:0] wd,
                       input logic rl);
    rst = rs; tvalid = vl; tuser = us; tlast = ls;
    rd_start = st; rd_width = wd; line_release = rl;
  endtask

  initial begin
    // rs vl us ls st wd rl | rdy wen sel ad av bs ra ba dv dn
    tbl.push_back(v(1,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 1,1,0,0,0,0,0,0,0,0));
    for (int i = 1; i < 5; i++)
      tbl.push_back(v(0,1,0,i==4,0,0,0, 1,1,0,i,0,0,0,0,0,0));
    for (int l = 1; l < 3; l++)
      for (int i = 0; i < 5; i++)
        tbl.push_back(v(0,1,0,i==4,0,0,0, 1,1,l,i,l,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,3,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,4,0, 1,0,0,0,2,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,2,1,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,2,1,1,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,2,1,2,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,2,1,3,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,2,1,3,1,1,1));
    tbl.push_back(v(0,0,0,0,1,0,0, 1,0,0,0,2,0,3,1,0,0));
    tbl.push_back(v(0,1,0,1,0,0,0, 1,1,3,0,2,0,3,1,0,0));
    tbl.push_back(v(0,1,0,1,0,0,0, 1,1,0,0,3,0,3,1,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 0,0,0,0,4,0,3,1,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 0,0,0,0,4,0,3,1,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,1,1,0,3,0,3,2,0,0));
    tbl.push_back(v(0,1,0,1,0,0,0, 1,1,1,1,3,0,3,2,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,4,0,3,2,0,0));
    tbl.push_back(v(0,1,0,1,0,0,1, 1,1,2,0,3,0,3,3,0,0));
    tbl.push_back(v(0,0,0,0,1,8,0, 1,0,0,0,3,0,3,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,3,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,1, 1,1,0,0,3,1,1,0,1,0));
    tbl.push_back(v(0,1,0,1,0,0,0, 1,1,0,1,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,0,0, 1,0,0,0,1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,3,0, 1,0,0,0,0,0,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,1,1,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,1,1,0,0,0,1,1,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0, 1,1,1,1,0,0,1,1,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,1,0,0,0,0,0,0,0,0));

    drive(1, 0, 0, 0, 0, 12'd0, 0);
    repeat (2) @(posedge clk);

    foreach (tbl[r]) begin
      @(negedge clk);
      drive(tbl[r].rst, tbl[r].vld, tbl[r].usr, tbl[r].lst,
            tbl[r].st, tbl[r].wid, tbl[r].rel);
      #1;
      chk("tready", r, 32'(tready), 32'(tbl[r].rdy));
      chk("wr_en", r, 32'(wr_en), 32'(tbl[r].wen));
      if (tbl[r].wen || tbl[r].rst) begin
        chk("wr_sel", r, 32'(wr_sel), 32'(tbl[r].sel));
        chk("wr_addr", r, 32'(wr_addr), 32'(tbl[r].addr));
      end
      chk("wr_ovf", r, 32'(wr_ovf), 32'd0);
      chk("lines_avail", r, 32'(lines_avail), 32'(tbl[r].avail));
      chk("rd_busy", r, 32'(rd_busy), 32'(tbl[r].busy));
      chk("rd_addr", r, 32'(rd_addr), 32'(tbl[r].raddr));
      chk("rd_base", r, 32'(rd_base), 32'(tbl[r].base));
      chk("rd_dvalid", r, 32'(rd_dvalid), 32'(tbl[r].dv));
      chk("rd_done", r, 32'(rd_done), 32'(tbl[r].done));
    end

    // 2050-pixel line: column clamps at 2047, one overflow pulse
    for (int i = 0; i < 2050; i++) begin
      @(negedge clk);
      drive(0, 1, i == 0, i == 2049, 0, 12'd0, 0);
      #1;
      chk("ovf_wr_en", 1000 + i, 32'(wr_en), 32'd1);
      chk("ovf_wr_addr", 1000 + i, 32'(wr_addr),
          (i < 2047) ? 32'(i) : 32'd2047);
      chk("ovf_pulse", 1000 + i, 32'(wr_ovf), 32'(i == 2047));
    end
    @(negedge clk);
    drive(0, 1, 0, 1, 0, 12'd0, 0);
    #1;
    chk("ovf_avail", 4000, 32'(lines_avail), 32'd1);
    chk("ovf_next_sel", 4000, 32'(wr_sel), 32'd1);
    chk("ovf_next_addr", 4000, 32'(wr_addr), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 12'd0, 0);
    #1;
    chk("post_avail", 4001, 32'(lines_avail), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/linebuffer_ctrl.md
Name: linebuffer_ctrl

Overview:
Sequences a ring of C_LINE_NUM single-port-write/registered-read line buffer RAMs (1-cycle read latency) inside the axis scaler. The write side accepts an AXI-Stream video input and steers each pixel to the current free line buffer at a column address. The read side generates a shared column-address sweep across all buffered lines for the vertical filter, and reports the oldest-line index. Lines are retired by explicit release from the consumer. Pixel data itself bypasses this block.

Parameters:
C_ADDRESS_WIDTH, 11, line buffer address width; max line length 2**C_ADDRESS_WIDTH pixels
C_LINE_NUM, 4, number of line buffers in ring; power of 2, 2..8
C_IDX_WIDTH, 2, log2(C_LINE_NUM)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tvalid  in  1  input beat valid
s_axis_tuser  in  1  start of frame, on first pixel
s_axis_tlast  in  1  end of line
s_axis_tready  out  1  input ready
wr_en  out  1  write strobe to selected line buffer
wr_sel  out  C_IDX_WIDTH  line buffer index being written
wr_addr  out  C_ADDRESS_WIDTH  write column
wr_ovf  out  1  1-cycle pulse: line exceeded 2**C_ADDRESS_WIDTH pixels
lines_avail  out  C_IDX_WIDTH+1  committed, unreleased lines
rd_start  in  1  request one read sweep (pulse)
rd_width  in  C_ADDRESS_WIDTH+1  pixels to sweep, sampled with rd_start
rd_busy  out  1  sweep in progress
rd_addr  out  C_ADDRESS_WIDTH  shared read column for all line buffers
rd_base  out  C_IDX_WIDTH  ring index of oldest committed line
rd_dvalid  out  1  line buffer outputs valid this cycle (rd_en delayed 1)
rd_done  out  1  1-cycle pulse with last rd_dvalid
line_release  in  1  retire oldest line (pulse)

Behaviour:
- Reset (rst=1 at clk edge): count=0, wr_idx=0, wcol=0, rd_base=0, read FSM IDLE. All outputs are 0, including s_axis_tready, rd_addr, rd_dvalid, rd_done, and wr_ovf.
- s_axis_tready = !rst_q & (count != C_LINE_NUM). This is combinational from registered state, so a release only frees the slot for the following cycle.
- Beat accepted = tvalid & tready. On an accepted beat, wr_en=1, wr_sel=wr_idx, and wr_addr=wcol; these are combinational, same cycle as the handshake.
- Column rule: after an accepted beat without tlast, wcol increments. When wcol = 2**C_ADDRESS_WIDTH-1, wcol holds and wr_ovf pulses. Further beats overwrite the last column until tlast.
- Line commit on accepted tlast: wcol<=0, wr_idx<=wr_idx+1 (mod C_LINE_NUM), count+1.
- Frame start: an accepted beat with tuser flushes the ring. count<=0, rd_base<=0, wr_idx<=0, and the read FSM is forced to IDLE (no rd_done). That beat is written to line 0, col 0; wcol<=1, or 0 with commit if tlast is also set. tuser wins over any simultaneous release or rd_start.
- Release: line_release with count>0 and rd_busy=0 gives rd_base+1 (mod) and count-1. It is ignored if count==0 or rd_busy=1.
- Simultaneous commit and release: both pointers advance and count is unchanged.
- lines_avail = count.
- Read FSM states:
  - IDLE: rd_start & count>0 & rd_width!=0 latches the width and moves to RUN. Otherwise rd_start is ignored.
  - RUN: rd_en=1 internally; rd_addr counts 0..width-1, one per cycle, with no backpressure. After the last address, move to DRAIN.
  - DRAIN: one cycle; emits the final rd_dvalid together with rd_done, then returns to IDLE.
- Read timing:
  - rd_busy=1 in RUN and DRAIN.
  - rd_dvalid = rd_en registered.
  - Data for rd_addr issued at cycle t is valid at cycle t+1.
  - rd_addr holds its last value in IDLE.
- Read-side stability: rd_base and count cannot decrease during a sweep. Writes into the free slot continue concurrently.
- Count bound: count never exceeds C_LINE_NUM. Commit is impossible when count==C_LINE_NUM because tready=0.

Test Plan:
- Reset, then 3 lines of 5 pixels (tuser on the first, tlast on each 5th), always valid -> wr_addr 0..4 per line, wr_sel 0,1,2, lines_avail=3, tready stays 1.
- With C_LINE_NUM=4, send 5 lines and no release -> after the 4th tlast tready=0 and the 5th line stalls. One line_release -> tready=1 next cycle, rd_base=1, and the 5th line is written with wr_sel=0.
- With lines_avail=2, rd_start with rd_width=4 -> rd_addr 0,1,2,3 on consecutive cycles, rd_dvalid on the 4 cycles one later, rd_done with the 4th, and rd_busy for 5 cycles. line_release during the sweep is ignored (rd_base unchanged).
- rd_start with count=0 or rd_width=0 -> no rd_busy, no rd_dvalid.
- 2050-pixel line with C_ADDRESS_WIDTH=11 -> wr_ovf pulses at col 2047, wr_addr holds at 2047 for the remaining beats, and tlast commits normally.
- With 3 lines committed and a sweep in RUN, a tuser beat is accepted -> rd_busy drops, no rd_done, lines_avail=0, rd_base=0, and the beat is written to wr_sel=0, wr_addr=0. rst asserted mid-line -> all outputs 0 on the next cycle.
